seq_nr_divider: RTL and testbench
=================================

Name: seq_nr_divider

Overview:
- Sequential unsigned non-restoring divider. It is the inverse-operation companion to the team's combinational add/sub datapath.
- Computes quotient and remainder of two DATA_WIDTH-bit operands, iterating one add-or-subtract step per clock.
- Sits behind a valid/ready request channel and a valid/ready response channel, for use in multi-cycle ALU/DSP paths.

Parameters:
- DATA_WIDTH, 8, operand/quotient/remainder width; legal range ≥2.

Ports:
- clk, input, 1, rising-edge clock
- rst, input, 1, synchronous active-high reset
- in_valid, input, 1, request valid
- in_ready, output, 1, block can accept a request
- dividend, input, DATA_WIDTH, unsigned dividend; sampled on request handshake
- divisor, input, DATA_WIDTH, unsigned divisor; sampled on request handshake
- out_valid, output, 1, result valid
- out_ready, input, 1, consumer accepts result
- quotient, output, DATA_WIDTH, unsigned quotient
- remainder, output, DATA_WIDTH, unsigned remainder
- div_by_zero, output, 1, flags a result produced with divisor == 0

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high, named clk and rst.
- Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
- in_ready is high only in IDLE.
- Request handshake: in_valid && in_ready at a rising edge. Operands are latched; inputs are don't-care afterwards.
- States and transitions:
  - IDLE→CALC on handshake with divisor≠0.
  - IDLE→DONE on handshake with divisor==0.
  - CALC: one step per cycle for DATA_WIDTH cycles, then →FIX.
  - FIX: one cycle, then →DONE.
  - DONE: holds until out_valid && out_ready, then →IDLE.
- Datapath:
  - Partial remainder P is signed, DATA_WIDTH+1 bits, initialised to 0.
  - Quotient shift register Q is initialised to dividend.
  - D = zero-extended divisor, DATA_WIDTH+1 bits.
- Each CALC step:
  - Shift {P,Q} left by 1.
  - If P was non-negative before the step, P = shifted P − D; otherwise P = shifted P + D.
  - Q[0] = ~P_new[MSB].
  - Subtract is implemented as shifted P + ~D + 1 via a single add/sub with control = ~P_old[MSB].
  - Carry-out is discarded; arithmetic is modulo 2^(DATA_WIDTH+1).
- FIX: if P[MSB]=1 then P = P + D, else hold.
  - remainder = P[DATA_WIDTH-1:0]
  - quotient = Q
- Latency: out_valid rises DATA_WIDTH+2 rising edges after the accept edge (DATA_WIDTH in CALC, FIX, then DONE).
- Divide by zero: out_valid rises 1 edge after accept, with quotient = all ones, remainder = dividend, div_by_zero=1.
  - div_by_zero is 0 for all other results.
- DONE holds quotient, remainder and div_by_zero stable while out_ready=0. There is no timeout.
- No back-to-back overlap: a new request can only be accepted in the cycle after the response handshake, because in_ready rises on entering IDLE.
- in_valid while busy is ignored; the request stays pending at the source.
- rst asserted in any state, including mid-CALC or in DONE with a pending result:
  - Next state is IDLE with all outputs at reset values.
  - The in-flight operation is discarded with no response.
- Outputs are registered; no combinational path from in_valid or out_ready to any output.

Decomposition:
- Shared package seq_div_pkg:
  - state enum typedef: IDLE, CALC, FIX, DONE (2 bits).
  - function returning counter width as $clog2(DATA_WIDTH+1).
- Sub-module nr_addsub_step, DATA_WIDTH+1 wide, combinational:
  - Inputs a, b, sub.
  - Output a + (b ^ {sub}) + sub.
  - Shared by the CALC step and FIX; FIX uses sub=0.

Test Plan (DATA_WIDTH=8):
- 100/7, out_ready=1 → out_valid exactly 10 edges after accept; quotient=14, remainder=2, div_by_zero=0; in_ready low throughout.
- Boundary values:
  - 255/1 → 255 r0
  - 5/9 → 0 r5
  - 255/255 → 1 r0
  - 0/3 → 0 r0
  - 128/2 → 64 r0
- 200/0 → out_valid 1 edge after accept; quotient=255, remainder=200, div_by_zero=1. Then 9/4 → 2 r1 with div_by_zero=0.
- 77/5 with out_ready low for 4 cycles in DONE → outputs hold 15 r2 stable; in_valid pulses during the hold are ignored. Release → handshake, in_ready rises the next cycle.
- rst asserted for 1 cycle at CALC step 4 of 100/7 → next edge IDLE, in_ready=1, out_valid=0, no response. Following 50/6 → 8 r2.
- Randomised 1000 operand pairs with random backpressure → quotient*divisor+remainder==dividend and remainder<divisor for divisor≠0; latency always 10.

Source files
------------

// File: rtl/seq_nr_divider_pkg.sv
// Shared types and sizing helpers for the sequential non-restoring divider.
package seq_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic int cnt_width(input int data_width);
      return $clog2(data_width + 1);
   endfunction

endpackage

// File: rtl/seq_nr_divider_addsub.sv
// Combinational add/sub step: y = a + (b ^ {sub}) + sub, carry-out dropped.
module nr_addsub_step #(
   parameter int WIDTH = 9
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] y
);

   assign y = a + (b ^ {WIDTH{sub}}) + {{(WIDTH-1){1'b0}}, sub};

endmodule

// File: rtl/seq_nr_divider.sv
// Unsigned non-restoring divider, one add/sub step per clock, valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// CALC  | DATA_WIDTH add-or-subtract steps on {P,Q}
// FIX   | final remainder correction when P is negative
// DONE  | result presented until the consumer accepts it
module seq_nr_divider
   import seq_div_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] quotient,
   output logic [DATA_WIDTH-1:0] remainder,
   output logic                  div_by_zero
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = cnt_width(DATA_WIDTH);

   state_t        state;
   state_t        state_next;
   logic [W:0]    p;
   logic [W-1:0]  q;
   logic [W:0]    d;
   logic [CW-1:0] cnt;

   logic [W:0]    add_a;
   logic          add_sub;
   logic [W:0]    add_y;
   logic          accept;
   logic          resp_hs;

   assign accept  = in_valid && in_ready;
   assign resp_hs = out_valid && out_ready;

   // CALC feeds the shifted partial remainder; FIX reuses the adder as a plain add.
   always_comb begin
      add_a   = p;
      add_sub = 1'b0;
      if (state == CALC) begin
         add_a   = {p[W-1:0], q[W-1]};
         add_sub = ~p[W];
      end
   end

   nr_addsub_step #(.WIDTH(W + 1)) u_step (
      .a   (add_a),
      .b   (d),
      .sub (add_sub),
      .y   (add_y)
   );

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = (divisor == '0) ? DONE : CALC;
         CALC: if (cnt == CW'(1)) state_next = FIX;
         FIX:  state_next = DONE;
         DONE: if (resp_hs) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         p           <= '0;
         q           <= '0;
         d           <= '0;
         cnt         <= '0;
      end else begin
         state     <= state_next;
         in_ready  <= (state_next == IDLE);
         // out_valid trails DONE entry by one edge and drops on the handshake edge
         out_valid <= (state == DONE) && !resp_hs;
         case (state)
            IDLE: begin
               if (accept) begin
                  p           <= '0;
                  q           <= dividend;
                  d           <= {1'b0, divisor};
                  cnt         <= CW'(W);
                  div_by_zero <= 1'b0;
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end
               end
            end
            CALC: begin
               p   <= add_y;
               q   <= {q[W-2:0], ~add_y[W]};
               cnt <= cnt - CW'(1);
            end
            FIX: begin
               if (p[W]) p <= add_y;
               quotient  <= q;
               remainder <= p[W] ? add_y[W-1:0] : p[W-1:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_nr_divider.sv
// Directed and randomised checks of seq_nr_divider against an arithmetic reference.
module tb_seq_nr_divider;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] dividend = '0;
   logic [7:0] divisor = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       div_by_zero;

   int n_cmp  = 0;
   int n_fail = 0;

   seq_nr_divider #(.DATA_WIDTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction; expectations come from plain integer division.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold,
                         input bit early_ready, input bit pulse_busy, input bit check_inv);
      logic [7:0] eq, er;
      logic       edbz;
      int         elat, lat, n, busy_ready;
      logic [7:0] hq, hr;
      if (b == 0) begin
         eq = 8'hFF; er = a; edbz = 1'b1; elat = 1;
      end else begin
         eq = 8'(int'(a) / int'(b)); er = 8'(int'(a) % int'(b)); edbz = 1'b0; elat = 10;
      end
      n = 0;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      chk("ready_before_req", in_ready, 1);
      dividend  = a;
      divisor   = b;
      in_valid  = 1'b1;
      out_ready = early_ready;
      tick();
      in_valid = 1'b0;
      dividend = 8'($urandom);
      divisor  = 8'($urandom);
      lat = 0;
      busy_ready = 0;
      while (!out_valid && lat < 64) begin
         in_valid = pulse_busy ? 1'($urandom) : 1'b0;
         tick();
         lat++;
         if (in_ready) busy_ready++;
      end
      in_valid = 1'b0;
      chk("latency", lat, elat);
      chk("in_ready_busy", busy_ready, 0);
      chk("quotient", quotient, eq);
      chk("remainder", remainder, er);
      chk("div_by_zero", div_by_zero, edbz);
      if (check_inv && b != 0) begin
         chk("inv_recompose", int'(quotient) * int'(b) + int'(remainder), int'(a));
         chk("inv_rem_lt_div", (remainder < b), 1);
      end
      hq = quotient;
      hr = remainder;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom);
         dividend = 8'($urandom);
         divisor  = 8'($urandom);
         tick();
         chk("hold_valid", out_valid, 1);
         chk("hold_in_ready", in_ready, 0);
         chk("hold_quotient", quotient, hq);
         chk("hold_remainder", remainder, hr);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("resp_valid_drop", out_valid, 0);
      chk("resp_in_ready", in_ready, 1);
   endtask

   initial begin
      int ovseen;
      rst = 1'b1;
      tick();
      tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_dbz", div_by_zero, 0);
      rst = 1'b0;
      tick();

      run_op(8'd100, 8'd7, 0, 1'b1, 1'b0, 1'b0);
      run_op(8'd255, 8'd1, 0, 1'b0, 1'b0, 1'b0);
      run_op(8'd5,   8'd9, 0, 1'b0, 1'b0, 1'b0);
      run_op(8'd255, 8'd255, 0, 1'b1, 1'b0, 1'b0);
      run_op(8'd0,   8'd3, 0, 1'b0, 1'b0, 1'b0);
      run_op(8'd128, 8'd2, 0, 1'b1, 1'b0, 1'b0);
      run_op(8'd200, 8'd0, 0, 1'b1, 1'b0, 1'b0);
      run_op(8'd9,   8'd4, 0, 1'b1, 1'b0, 1'b0);
      run_op(8'd77,  8'd5, 4, 1'b0, 1'b1, 1'b0);

      // Abort 100/7 mid-calculation; nothing may come out afterwards.
      dividend = 8'd100;
      divisor  = 8'd7;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_quotient", quotient, 0);
      chk("abort_remainder", remainder, 0);
      ovseen = 0;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (out_valid) ovseen++;
      end
      chk("abort_no_response", ovseen, 0);
      run_op(8'd50, 8'd6, 0, 1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 1000; i++) begin
         logic [7:0] ra, rb;
         int         h;
         bit         er;
         ra = 8'($urandom);
         rb = 8'($urandom_range(0, 255));
         er = 1'($urandom);
         h  = er ? 0 : $urandom_range(0, 3);
         run_op(ra, rb, h, er, 1'($urandom), 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
